// File: rtl/axi_rdata_arbiter_if.sv
// axi_rdata_arbiter_if: shared R-channel bundle between requesting slaves and the read-data return path
//   S_MASTER/S_ID/S_DATA  per-slave fields, slave i at [i*width +: width]
//   S_LAST/S_VALID        per-slave beat flags; S_READY per-slave accept
//   MASTER/ID/DATA/LAST   granted beat; VALID/READY output handshake
//   GRANT                 one-hot grant, 0 when idle; BEAT_CNT beats accepted in current burst
//   modport master is the arbiter's view, modport slave the surrounding fabric's view
interface axi_rdata_arbiter_if #(
    parameter int slaves = 4,
    parameter int masters = 4,
    parameter int id_bits = 2,
    parameter int data_width = 64
);
    logic [slaves*masters-1:0]    S_MASTER;
    logic [slaves*id_bits-1:0]    S_ID;
    logic [slaves*data_width-1:0] S_DATA;
    logic [slaves-1:0]            S_LAST;
    logic [slaves-1:0]            S_VALID;
    logic [slaves-1:0]            S_READY;
    logic [masters-1:0]           MASTER;
    logic [id_bits-1:0]           ID;
    logic [data_width-1:0]        DATA;
    logic                         LAST;
    logic                         VALID;
    logic                         READY;
    logic [slaves-1:0]            GRANT;
    logic [7:0]                   BEAT_CNT;
    modport master (
        input  S_MASTER, S_ID, S_DATA, S_LAST, S_VALID, READY,
        output S_READY, MASTER, ID, DATA, LAST, VALID, GRANT, BEAT_CNT
    );
    modport slave (
        output S_MASTER, S_ID, S_DATA, S_LAST, S_VALID, READY,
        input  S_READY, MASTER, ID, DATA, LAST, VALID, GRANT, BEAT_CNT
    );
endinterface

// File: rtl/axi_rdata_arbiter.sv
// axi_rdata_arbiter: round-robin arbiter sharing one R return path, grant locked per burst
//   CLK     clock, rising edge
//   RESETN  synchronous reset, active low
//   bus     axi_rdata_arbiter_if.master: per-slave R channels in, granted beat out, GRANT/BEAT_CNT status
module axi_rdata_arbiter #(
    parameter int slaves = 4,
    parameter int masters = 4,
    parameter int id_bits = 2,
    parameter int data_width = 64
) (
    input logic CLK,
    input logic RESETN,
    axi_rdata_arbiter_if.master bus
);
    localparam int pw = slaves > 1 ? $clog2(slaves) : 1;
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_n;
    logic [slaves-1:0] grant, grant_n;
    logic [pw-1:0] ptr, ptr_n, pick, idx, g;
    logic [7:0] cnt, cnt_n;
    logic accept;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= IDLE;
            grant <= '0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
        end
    end

    // Descending scan so the last hit is the one closest to ptr in rotation order.
    always_comb begin
        pick = '0;
        idx = '0;
        for (int k = slaves - 1; k >= 0; k--) begin
            idx = pw'((int'(ptr) + k) % slaves);
            if (bus.S_VALID[idx]) pick = idx;
        end
    end

    always_comb begin
        g = '0;
        for (int i = 0; i < slaves; i++) if (grant[i]) g = pw'(i);
    end

    assign accept = state == BURST && bus.S_VALID[g] && bus.READY;

    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n = ptr;
        cnt_n = cnt;
        if (state == IDLE) begin
            if (|bus.S_VALID) begin
                state_n = BURST;
                grant_n = '0;
                grant_n[pick] = 1'b1;
                cnt_n = '0;
            end
        end else if (accept) begin
            cnt_n = cnt == 8'hff ? cnt : cnt + 8'd1;
            if (bus.S_LAST[g]) begin
                state_n = IDLE;
                grant_n = '0;
                ptr_n = pw'((int'(g) + 1) % slaves);
            end
        end
    end

    // The granted slave is wired straight through; the arbiter holds no beat storage.
    always_comb begin
        bus.VALID = state == BURST && bus.S_VALID[g];
        bus.S_READY = state == BURST ? grant & {slaves{bus.READY}} : '0;
        bus.MASTER = state == BURST ? bus.S_MASTER[g*masters +: masters] : '0;
        bus.ID = state == BURST ? bus.S_ID[g*id_bits +: id_bits] : '0;
        bus.DATA = state == BURST ? bus.S_DATA[g*data_width +: data_width] : '0;
        bus.LAST = state == BURST && bus.S_LAST[g];
        bus.GRANT = grant;
        bus.BEAT_CNT = cnt;
    end
endmodule

// File: tb/tb_axi_rdata_arbiter.sv
// tb_axi_rdata_arbiter: vector table, hand sequences and randomized model checks for axi_rdata_arbiter
module tb_axi_rdata_arbiter;
    localparam int S = 4, M = 4, IB = 2, DW = 64;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int nb[S];
    int bt[S];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_rdata_arbiter_if #(.slaves(S), .masters(M), .id_bits(IB), .data_width(DW)) bus ();
    axi_rdata_arbiter #(.slaves(S), .masters(M), .id_bits(IB), .data_width(DW)) dut (
        .CLK(clk), .RESETN(resetn), .bus(bus)
    );

    function automatic logic [DW-1:0] beat_data(input int i, input int n, input int b);
        return {8'(i), 24'(n), 32'(b)};
    endfunction
    function automatic logic [IB-1:0] beat_id(input int i, input int n);
        return IB'(i + n);
    endfunction
    function automatic logic [M-1:0] beat_mst(input int i, input int n);
        return M'(1) << ((i + n) % M);
    endfunction

    always_comb begin
        bus.S_DATA = '0;
        bus.S_ID = '0;
        bus.S_MASTER = '0;
        for (int i = 0; i < S; i++) begin
            bus.S_DATA[i*DW +: DW] = beat_data(i, nb[i], bt[i]);
            bus.S_ID[i*IB +: IB] = beat_id(i, nb[i]);
            bus.S_MASTER[i*M +: M] = beat_mst(i, nb[i]);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // own = index of the slave that should hold the grant, -1 when idle
    task automatic expect_out(input string tag, input int own, input int cnt);
        logic [S-1:0] g;
        int o;
        o = own < 0 ? 0 : own;
        g = own < 0 ? '0 : S'(1) << own;
        check({tag, " GRANT"}, 64'(bus.GRANT), 64'(g));
        check({tag, " VALID"}, 64'(bus.VALID), 64'(own < 0 ? 1'b0 : bus.S_VALID[o]));
        check({tag, " S_READY"}, 64'(bus.S_READY), 64'(bus.READY ? g : '0));
        check({tag, " BEAT_CNT"}, 64'(bus.BEAT_CNT), 64'(cnt));
        check({tag, " DATA"}, bus.DATA, own < 0 ? '0 : beat_data(o, nb[o], bt[o]));
        check({tag, " ID"}, 64'(bus.ID), 64'(own < 0 ? '0 : beat_id(o, nb[o])));
        check({tag, " MASTER"}, 64'(bus.MASTER), 64'(own < 0 ? '0 : beat_mst(o, nb[o])));
        check({tag, " LAST"}, 64'(bus.LAST), 64'(own < 0 ? 1'b0 : bus.S_LAST[o]));
    endtask

    typedef struct {
        bit rn;
        logic [S-1:0] sv;
        logic [S-1:0] sl;
        bit rdy;
        int own;
        int cnt;
    } vec_t;

    function automatic vec_t v(input bit rn, input logic [S-1:0] sv, input logic [S-1:0] sl,
                               input bit rdy, input int own, input int cnt);
        vec_t r;
        r.rn = rn; r.sv = sv; r.sl = sl; r.rdy = rdy; r.own = own; r.cnt = cnt;
        return r;
    endfunction

    vec_t tab[$];
    int rem[S];
    bit hold[S];
    logic [S-1:0] sv, sl;
    int owner, mptr, mcnt, acc;

    initial begin
        // reset held with every slave requesting
        bus.S_VALID = '1; bus.S_LAST = '0; bus.READY = 1'b1; resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 expect_out("reset", -1, 0);

        // slave 2 four-beat burst
        tab.push_back(v(1, 4'b0100, 4'b0000, 1, -1, 0));
        tab.push_back(v(1, 4'b0100, 4'b0000, 1, 2, 0));
        tab.push_back(v(1, 4'b0100, 4'b0000, 1, 2, 1));
        tab.push_back(v(1, 4'b0100, 4'b0000, 1, 2, 2));
        tab.push_back(v(1, 4'b0100, 4'b0100, 1, 2, 3));
        tab.push_back(v(1, 4'b0000, 4'b0000, 1, -1, 4));
        tab.push_back(v(0, 4'b0000, 4'b0000, 1, -1, 4));
        // all four request single-beat bursts: rotating grants, a bubble between each
        tab.push_back(v(1, 4'b1111, 4'b1111, 1, -1, 0));
        tab.push_back(v(1, 4'b1111, 4'b1111, 1, 0, 0));
        tab.push_back(v(1, 4'b1110, 4'b1110, 1, -1, 1));
        tab.push_back(v(1, 4'b1110, 4'b1110, 1, 1, 0));
        tab.push_back(v(1, 4'b1100, 4'b1100, 1, -1, 1));
        tab.push_back(v(1, 4'b1100, 4'b1100, 1, 2, 0));
        tab.push_back(v(1, 4'b1000, 4'b1000, 1, -1, 1));
        tab.push_back(v(1, 4'b1000, 4'b1000, 1, 3, 0));
        tab.push_back(v(1, 4'b0000, 4'b0000, 1, -1, 1));
        // slave 0 drops VALID mid-burst while slave 3 requests: grant stays locked
        tab.push_back(v(1, 4'b0001, 4'b0000, 1, -1, 1));
        tab.push_back(v(1, 4'b0001, 4'b0000, 1, 0, 0));
        tab.push_back(v(1, 4'b1000, 4'b1000, 1, 0, 1));
        tab.push_back(v(1, 4'b1000, 4'b1000, 1, 0, 1));
        tab.push_back(v(1, 4'b1001, 4'b1001, 1, 0, 1));
        tab.push_back(v(1, 4'b1000, 4'b1000, 1, -1, 2));
        tab.push_back(v(1, 4'b1000, 4'b1000, 1, 3, 0));
        tab.push_back(v(1, 4'b0000, 4'b0000, 1, -1, 1));
        foreach (tab[k]) begin
            @(negedge clk);
            resetn = tab[k].rn; bus.S_VALID = tab[k].sv; bus.S_LAST = tab[k].sl; bus.READY = tab[k].rdy;
            #1 expect_out($sformatf("vec%0d", k), tab[k].own, tab[k].cnt);
        end

        // slave 1 stalled by READY=0 for three cycles mid-burst
        @(negedge clk); bus.S_VALID = 4'b0010; bus.S_LAST = '0; bus.READY = 1'b1;
        #1 expect_out("t4 arb", -1, 1);
        @(negedge clk); #1 expect_out("t4 b0", 1, 0);
        @(negedge clk); bt[1] = 1; bus.READY = 1'b0;
        #1 expect_out("t4 stall0", 1, 1);
        for (int j = 1; j < 3; j++) begin
            @(negedge clk); #1 expect_out($sformatf("t4 stall%0d", j), 1, 1);
        end
        @(negedge clk); bus.READY = 1'b1; #1 expect_out("t4 b1", 1, 1);
        @(negedge clk); bt[1] = 2; bus.S_LAST = 4'b0010; #1 expect_out("t4 b2", 1, 2);
        @(negedge clk); bus.S_VALID = '0; bus.S_LAST = '0; #1 expect_out("t4 done", -1, 3);

        // reset during beat 2 of a slave 3 burst; pointer must return to 0
        @(negedge clk); bus.S_VALID = 4'b1000; bt[3] = 0; #1 expect_out("t6 arb", -1, 3);
        @(negedge clk); #1 expect_out("t6 b0", 3, 0);
        @(negedge clk); bt[3] = 1; #1 expect_out("t6 b1", 3, 1);
        @(negedge clk); bt[3] = 2; resetn = 1'b0; #1 expect_out("t6 b2", 3, 2);
        @(negedge clk); resetn = 1'b1; bus.S_VALID = 4'b1010; bus.S_LAST = 4'b0010; bt[3] = 0;
        #1 expect_out("t6 post", -1, 0);
        @(negedge clk); #1 expect_out("t6 rearb", 1, 0);
        @(negedge clk); bus.S_VALID = '0; bus.S_LAST = '0; #1 expect_out("t6 done", -1, 1);

        // 259-beat burst: BEAT_CNT saturates at 255
        @(negedge clk); bus.S_VALID = 4'b0100; #1 expect_out("sat arb", -1, 1);
        for (int j = 1; j <= 259; j++) begin
            @(negedge clk);
            if (j == 259) bus.S_LAST = 4'b0100;
            if (j >= 254) begin
                #1 expect_out($sformatf("sat b%0d", j), 2, j - 1 > 255 ? 255 : j - 1);
            end
        end
        @(negedge clk); bus.S_VALID = '0; bus.S_LAST = '0; #1 expect_out("sat done", -1, 255);

        // randomized traffic against the reference model
        @(negedge clk); resetn = 1'b0;
        owner = -1; mptr = 0; mcnt = 0; acc = -1;
        for (int i = 0; i < S; i++) begin rem[i] = 0; hold[i] = 1'b0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            resetn = 1'b1;
            if (acc >= 0) begin rem[acc]--; bt[acc]++; end
            for (int i = 0; i < S; i++) begin
                if (rem[i] == 0 && $urandom_range(3) == 0) begin
                    rem[i] = $urandom_range(5, 1); nb[i]++; bt[i] = 0;
                end
                sv[i] = rem[i] > 0 && (hold[i] || $urandom_range(3) != 0);
                sl[i] = rem[i] == 1;
            end
            bus.S_VALID = sv; bus.S_LAST = sl; bus.READY = $urandom_range(3) != 0;
            #1 expect_out($sformatf("rnd%0d", cyc), owner, mcnt);
            acc = -1;
            if (owner < 0) begin
                if (|sv) begin
                    for (int k = S - 1; k >= 0; k--) if (sv[(mptr + k) % S]) owner = (mptr + k) % S;
                    mcnt = 0;
                end
            end else if (sv[owner] && bus.READY) begin
                acc = owner;
                mcnt = mcnt < 255 ? mcnt + 1 : 255;
                if (sl[owner]) begin mptr = (owner + 1) % S; owner = -1; end
            end
            for (int i = 0; i < S; i++) hold[i] = sv[i] && i != acc;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
